sqrt_seq: RTL and testbench

SQRT_SEQ -- requirements
Module: sqrt_seq

---
 rtl/sqrt_seq.sv | 127 ++++++++++++
 tb/tb_sqrt_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_seq.sv
// Sequencer for an external iterative square-root unit: a 2-entry input FIFO feeds one
// operation at a time to the unit, with a watchdog on the unit's completion and a single
// registered output slot towards the consumer.
module sqrt_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 64  // legal range 2..255
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             sq_go_o,
    output logic [WIDTH-1:0] sq_in_o,
    input  logic             sq_done_i,
    input  logic [WIDTH-1:0] sq_out_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam logic [7:0] WdogLast = 8'(TIMEOUT - 1);

    typedef enum logic {StIdle, StRun} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] fifo_q [2];
    logic             rd_ptr_q, wr_ptr_q;
    logic [1:0]       count_q, count_d;
    logic             sq_go_q;
    logic [WIDTH-1:0] sq_in_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             err_q;
    logic [7:0]       wdog_q;

    logic push, pop, slot_free;

    // Handshake decode; in_ready depends only on the registered count.
    always_comb begin
        in_ready_o = (count_q != 2'd2);
        push       = in_valid_i && in_ready_o;
        slot_free  = !out_valid_q || out_ready_i;
        pop        = (state_q == StIdle) && (count_q != 2'd0) && slot_free;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!push && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    // Input FIFO storage and pointers.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= in_data_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    // Control FSM with registered go/operand, output slot, watchdog and sticky error.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            sq_go_q     <= 1'b0;
            sq_in_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
            wdog_q      <= 8'd0;
        end else begin
            // Consumer handshake; a capture below on the same edge overrides this.
            if (out_valid_q && out_ready_i) begin
                out_valid_q <= 1'b0;
            end
            unique case (state_q)
                StIdle: begin
                    // Completion pulses arriving here are deliberately ignored.
                    if (pop) begin
                        state_q <= StRun;
                        sq_go_q <= 1'b1;
                        sq_in_q <= fifo_q[rd_ptr_q];
                        wdog_q  <= 8'd0;
                    end
                end
                StRun: begin
                    if (sq_done_i) begin
                        // Completion wins over a watchdog expiring on the same cycle.
                        out_data_q  <= sq_out_i;
                        out_valid_q <= 1'b1;
                        sq_go_q     <= 1'b0;
                        state_q     <= StIdle;
                    end else if (wdog_q == WdogLast) begin
                        err_q   <= 1'b1;
                        sq_go_q <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        wdog_q <= wdog_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign sq_go_o     = sq_go_q;
    assign sq_in_o     = sq_in_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign busy_o      = (state_q == StRun);
    assign err_o       = err_q;

endmodule

// File: tb/tb_sqrt_seq.sv
// Directed bench for sqrt_seq with a behavioural model of the downstream sqrt unit.
module tb_sqrt_seq;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        sq_go;
    logic [31:0] sq_in;
    logic        sq_done;
    logic [31:0] sq_out;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Sqrt unit model: completes after model_lat cycles of go (0 = never completes).
    int          model_lat = 0;
    int          cnt_q = 0;
    logic        force_done = 1'b0;
    logic [31:0] force_out = 32'd0;

    always #5 clk = ~clk;

    sqrt_seq #(
        .WIDTH  (32),
        .TIMEOUT(TO)
    ) dut (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (in_data),
        .sq_go_o    (sq_go),
        .sq_in_o    (sq_in),
        .sq_done_i  (sq_done),
        .sq_out_i   (sq_out),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .busy_o     (busy),
        .err_o      (err)
    );

    function automatic logic [31:0] isqrt(input logic [31:0] v);
        logic [31:0] r;
        logic [31:0] t;
        r = 32'd0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (32'd1 << b);
            if (64'(t) * 64'(t) <= 64'(v)) r = t;
        end
        return r;
    endfunction

    always @(posedge clk) cnt_q <= sq_go ? cnt_q + 1 : 0;

    assign sq_done = force_done || (model_lat != 0 && sq_go && cnt_q == model_lat - 1);
    assign sq_out  = force_done ? force_out : isqrt(sq_in);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
        end
    endtask

    // Running invariants: busy tracks go, operand stable during an operation.
    logic        busy_prev = 1'b0;
    logic [31:0] in_prev = 32'd0;
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            check("busy_eq_go", busy, sq_go);
            if (busy && busy_prev) check("sq_in_stable", sq_in, in_prev);
        end
        busy_prev <= busy && (reset_n === 1'b1);
        in_prev   <= sq_in;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = v;
        tick();
        in_valid = 1'b0;
    endtask

    // One isolated operation with the consumer always ready.
    task automatic run_op(input logic [31:0] opnd, input int lat, input logic [31:0] exp,
                          input logic exp_err, input string name);
        int n;
        model_lat = lat;
        out_ready = 1'b1;
        push(opnd);
        check({name, "_go_before_pop"}, {31'd0, sq_go}, 32'd0);
        tick();
        check({name, "_go_after_pop"}, {31'd0, sq_go}, 32'd1);
        check({name, "_sq_in"}, sq_in, opnd);
        n = 0;
        while (sq_go === 1'b1 && n < 300) begin
            n++;
            tick();
        end
        if (lat == 0 || lat > TO) begin
            check({name, "_go_cycles"}, n, TO);
            check({name, "_no_valid"}, {31'd0, out_valid}, 32'd0);
        end else begin
            check({name, "_go_cycles"}, n, lat);
            check({name, "_valid"}, {31'd0, out_valid}, 32'd1);
            check({name, "_data"}, out_data, exp);
        end
        check({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
        tick();
        check({name, "_valid_one_cycle"}, {31'd0, out_valid}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] opnd;
        int          lat;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] got [$];
    int          n;

    initial begin
        vecs[0] = '{32'd144, 24, 32'd12};
        vecs[1] = '{32'd0, 1, 32'd0};
        vecs[2] = '{32'd1, 2, 32'd1};
        vecs[3] = '{32'd2, 5, 32'd1};
        vecs[4] = '{32'd1000000, 7, 32'd1000};
        vecs[5] = '{32'hFFFFFFFF, 4, 32'd65535};
        vecs[6] = '{32'd99, 64, 32'd9};   // done on the watchdog's last cycle
        vecs[7] = '{32'd15, 63, 32'd3};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'd0;
        out_ready = 1'b0;
        #1;
        check("rst_go", {31'd0, sq_go}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out_data", out_data, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].opnd, vecs[i].lat, vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
        end

        // Completion pulse while idle is ignored.
        force_out  = 32'd7;
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        check("idle_done_valid", {31'd0, out_valid}, 32'd0);
        check("idle_done_data", out_data, 32'd3);
        check("idle_done_busy", {31'd0, busy}, 32'd0);

        // Back-pressure: three operands, consumer stalled.
        model_lat = 3;
        out_ready = 1'b0;
        push(32'd4);
        push(32'd9);
        push(32'd16);
        check("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
        n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("bp_first_valid", {31'd0, out_valid}, 32'd1);
        check("bp_first_data", out_data, 32'd2);
        repeat (10) tick();
        check("bp_stall_valid", {31'd0, out_valid}, 32'd1);
        check("bp_stall_data", out_data, 32'd2);
        check("bp_stall_busy", {31'd0, busy}, 32'd0);
        check("bp_stall_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        n = 0;
        while (got.size() < 3 && n < 60) begin
            if (out_valid === 1'b1) got.push_back(out_data);
            tick();
            n++;
        end
        check("bp_count", got.size(), 3);
        while (got.size() < 3) got.push_back(32'hDEAD);
        check("bp_res0", got[0], 32'd2);
        check("bp_res1", got[1], 32'd3);
        check("bp_res2", got[2], 32'd4);
        repeat (3) tick();

        // Watchdog expiry, then continued operation with sticky error.
        run_op(32'd77, 0, 32'd0, 1'b1, "timeout");
        run_op(32'd25, 6, 32'd5, 1'b1, "after_to");

        // Reset in the middle of an operation.
        model_lat = 30;
        push(32'd49);
        n = 0;
        while (sq_go !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        repeat (5) tick();
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mr_go", {31'd0, sq_go}, 32'd0);
        check("mr_sq_in", sq_in, 32'd0);
        check("mr_out_valid", {31'd0, out_valid}, 32'd0);
        check("mr_out_data", out_data, 32'd0);
        check("mr_busy", {31'd0, busy}, 32'd0);
        check("mr_err", {31'd0, err}, 32'd0);
        tick();
        reset_n = 1'b1;
        check("mr_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (5) tick();
        check("mr_no_result", {31'd0, out_valid}, 32'd0);
        run_op(32'd81, 10, 32'd9, 1'b0, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: actual running, expected finished");
        $fatal(1, "simulation time limit");
    end

endmodule
